rx_frame_assembler: RTL and testbench

- Sits between the UART byte receiver and main memory on the receive path.
- Packs a stream of received bytes into one 136-bit matrix-entry word (17 bytes).
- Delivers each completed word as a one-cycle write strobe plus data, the form memory's write port consumes (wen/inData).
- Discards partial frames on inter-byte timeout or a UART framing error, so memory never sees a torn word.

---
 rtl/rx_frame_assembler.sv | 175 +++++++++++++++++
 tb/tb_rx_frame_assembler.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rx_frame_assembler.sv
// Packs UART bytes MSB-first into one 8*FRAME_BYTES word and presents it as a single-cycle write strobe.
// Optional feature macro RX_FRAME_CHECKSUM_EN: appends an XOR checksum byte per frame and adds csum_err.
module rx_frame_assembler #(
  parameter int FRAME_BYTES    = 17,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [7:0]               byte_data,
  input  logic                     byte_valid,
  input  logic                     byte_err,
  output logic [8*FRAME_BYTES-1:0] frame_data,
  output logic                     frame_valid,
  output logic                     busy,
  output logic [4:0]               byte_count,
  output logic                     timeout_err,
`ifdef RX_FRAME_CHECKSUM_EN
  output logic                     csum_err,
`endif
  output logic                     rx_err
);

  localparam int W  = 8 * FRAME_BYTES;
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
`ifdef RX_FRAME_CHECKSUM_EN
  localparam int FRAME_LEN = FRAME_BYTES + 1;
`else
  localparam int FRAME_LEN = FRAME_BYTES;
`endif
  localparam logic [4:0]    LAST_COUNT   = 5'(FRAME_LEN - 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, COLLECT, EMIT} state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  shift_q, shift_d;
  logic [W-1:0]  frame_data_q, frame_data_d;
  logic          frame_valid_q, frame_valid_d;
  logic [4:0]    byte_count_q, byte_count_d;
  logic [CW-1:0] idle_cnt_q, idle_cnt_d;
  logic          timeout_err_q, timeout_err_d;
  logic          rx_err_q, rx_err_d;
`ifdef RX_FRAME_CHECKSUM_EN
  logic [7:0]    csum_q, csum_d;
  logic          csum_ok_q, csum_ok_d;
  logic          csum_err_q, csum_err_d;
`endif

  logic good_byte;
  assign good_byte = byte_valid && !byte_err;

  always_comb begin
    // NOTE: every variable gets a default first so no path through the logic can infer a latch.
    state_d       = state_q;
    shift_d       = shift_q;
    frame_data_d  = frame_data_q;
    frame_valid_d = 1'b0;
    byte_count_d  = byte_count_q;
    idle_cnt_d    = idle_cnt_q;
    timeout_err_d = 1'b0;
    rx_err_d      = 1'b0;
`ifdef RX_FRAME_CHECKSUM_EN
    csum_d        = csum_q;
    csum_ok_d     = csum_ok_q;
    csum_err_d    = 1'b0;
`endif

    if (state_q == EMIT) begin
`ifdef RX_FRAME_CHECKSUM_EN
      if (csum_ok_q) begin
        frame_data_d  = shift_q;
        frame_valid_d = 1'b1;
      end else begin
        csum_err_d = 1'b1;
      end
`else
      frame_data_d  = shift_q;
      frame_valid_d = 1'b1;
`endif
      state_d = IDLE;
    end

    if (state_q == COLLECT) begin
      if (good_byte) begin
        idle_cnt_d   = '0;
        byte_count_d = byte_count_q + 5'd1;
        if (byte_count_q == LAST_COUNT) begin
          state_d      = EMIT;
          byte_count_d = '0;
        end
`ifdef RX_FRAME_CHECKSUM_EN
        if (byte_count_q == LAST_COUNT) begin
          csum_ok_d = (csum_q == byte_data);
        end else begin
          shift_d = {shift_q[W-9:0], byte_data};
          csum_d  = csum_q ^ byte_data;
        end
`else
        shift_d = {shift_q[W-9:0], byte_data};
`endif
      end else if (byte_valid) begin
        rx_err_d     = 1'b1;
        byte_count_d = '0;
        idle_cnt_d   = '0;
        state_d      = IDLE;
      end else if (idle_cnt_q == TIMEOUT_LAST) begin
        timeout_err_d = 1'b1;
        byte_count_d  = '0;
        idle_cnt_d    = '0;
        state_d       = IDLE;
      end else begin
        idle_cnt_d = idle_cnt_q + CW'(1);
      end
    end else begin
      // IDLE and EMIT alike: a clean byte opens the next frame, so none is dropped during EMIT.
      idle_cnt_d = '0;
      if (good_byte) begin
        shift_d      = {shift_q[W-9:0], byte_data};
        byte_count_d = 5'd1;
        state_d      = COLLECT;
`ifdef RX_FRAME_CHECKSUM_EN
        csum_d       = byte_data;
`endif
      end else begin
        byte_count_d = '0;
        if (byte_valid) rx_err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the shift register is reset too, so a reset mid-frame leaves no stale partial bytes.
      state_q       <= IDLE;
      shift_q       <= '0;
      frame_data_q  <= '0;
      frame_valid_q <= 1'b0;
      byte_count_q  <= '0;
      idle_cnt_q    <= '0;
      timeout_err_q <= 1'b0;
      rx_err_q      <= 1'b0;
`ifdef RX_FRAME_CHECKSUM_EN
      csum_q        <= '0;
      csum_ok_q     <= 1'b0;
      csum_err_q    <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge value of its peers.
      state_q       <= state_d;
      shift_q       <= shift_d;
      frame_data_q  <= frame_data_d;
      frame_valid_q <= frame_valid_d;
      byte_count_q  <= byte_count_d;
      idle_cnt_q    <= idle_cnt_d;
      timeout_err_q <= timeout_err_d;
      rx_err_q      <= rx_err_d;
`ifdef RX_FRAME_CHECKSUM_EN
      csum_q        <= csum_d;
      csum_ok_q     <= csum_ok_d;
      csum_err_q    <= csum_err_d;
`endif
    end
  end

  assign frame_data  = frame_data_q;
  assign frame_valid = frame_valid_q;
  assign busy        = (state_q != IDLE);
  assign byte_count  = byte_count_q;
  assign timeout_err = timeout_err_q;
  assign rx_err      = rx_err_q;
`ifdef RX_FRAME_CHECKSUM_EN
  assign csum_err    = csum_err_q;
`endif

endmodule

// File: tb/tb_rx_frame_assembler.sv
// Directed bench for rx_frame_assembler; the idle timeout is shortened to keep the run brief.
`timescale 1ns/1ps
module tb_rx_frame_assembler;
  localparam int FB = 17;
  localparam int T  = 1000;
  localparam int W  = 8 * FB;
`ifdef RX_FRAME_CHECKSUM_EN
  localparam int FLEN = FB + 1;
`else
  localparam int FLEN = FB;
`endif

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [7:0]   byte_data = 8'h00;
  logic         byte_valid = 1'b0;
  logic         byte_err = 1'b0;
  logic [W-1:0] frame_data;
  logic         frame_valid, busy, timeout_err, rx_err;
  logic [4:0]   byte_count;
`ifdef RX_FRAME_CHECKSUM_EN
  logic         csum_err;
`endif

  int           n_checks = 0;
  int           n_fail = 0;
  logic [8:0]   exp_s;
  logic [W-1:0] exp_w;
  logic [W-1:0] last_word;

  always #5 clk = ~clk;

  rx_frame_assembler #(.FRAME_BYTES(FB), .TIMEOUT_CYCLES(T)) dut (
    .clk         (clk),
    .reset       (reset),
    .byte_data   (byte_data),
    .byte_valid  (byte_valid),
    .byte_err    (byte_err),
    .frame_data  (frame_data),
    .frame_valid (frame_valid),
    .busy        (busy),
    .byte_count  (byte_count),
    .timeout_err (timeout_err),
`ifdef RX_FRAME_CHECKSUM_EN
    .csum_err    (csum_err),
`endif
    .rx_err      (rx_err)
  );

  // {frame_valid, busy, timeout_err, rx_err, byte_count}
  function automatic logic [8:0] status();
    return {frame_valid, busy, timeout_err, rx_err, byte_count};
  endfunction

  function automatic logic [7:0] data_byte(input logic [7:0] base, input logic [7:0] step, input int i);
    logic [7:0] b;
    b = base;
    for (int k = 0; k < i; k++) b = b + step;
    return b;
  endfunction

  function automatic logic [7:0] frame_byte(input logic [7:0] base, input logic [7:0] step, input int i);
    logic [7:0] x;
    x = 8'h00;
    if (i < FB) return data_byte(base, step, i);
    for (int k = 0; k < FB; k++) x = x ^ data_byte(base, step, k);
    return x;
  endfunction

  function automatic logic [W-1:0] exp_word(input logic [7:0] base, input logic [7:0] step);
    logic [W-1:0] w;
    w = '0;
    for (int k = 0; k < FB; k++) w[W-1-8*k -: 8] = data_byte(base, step, k);
    return w;
  endfunction

  // Called on a negedge; the byte is sampled at the next posedge and the task returns on the following negedge.
  task automatic send_byte(input logic [7:0] b, input logic err);
    byte_data  = b;
    byte_err   = err;
    byte_valid = 1'b1;
    @(negedge clk);
    byte_valid = 1'b0;
    byte_err   = 1'b0;
    byte_data  = 8'h00;
  endtask

  task automatic send_bytes(input logic [7:0] base, input logic [7:0] step, input int from, input int to,
                            input int gap);
    for (int i = from; i <= to; i++) begin
      repeat (gap - 1) @(negedge clk);
      send_byte(frame_byte(base, step, i), 1'b0);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    exp_s = 9'd0;
    n_checks++; if (status() !== exp_s) begin n_fail++; $display("FAIL reset_status: got %b expected %b", status(), exp_s); end
    n_checks++; if (frame_data !== '0) begin n_fail++; $display("FAIL reset_data: got %h expected 0", frame_data); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single_frame();
    send_bytes(8'h01, 8'h01, 0, 4, 200);
    exp_s = {1'b0, 1'b1, 1'b0, 1'b0, 5'd5};
    n_checks++; if (status() !== exp_s) begin n_fail++; $display("FAIL single_mid: got %b expected %b", status(), exp_s); end
    send_bytes(8'h01, 8'h01, 5, FLEN - 1, 200);
    exp_s = {1'b0, 1'b1, 1'b0, 1'b0, 5'd0};
    n_checks++; if (status() !== exp_s) begin n_fail++; $display("FAIL single_emit_slot: got %b expected %b", status(), exp_s); end
    @(negedge clk);
    exp_s = {1'b1, 1'b0, 1'b0, 1'b0, 5'd0};
    exp_w = 136'h0102030405060708090a0b0c0d0e0f1011;
    n_checks++; if (status() !== exp_s) begin n_fail++; $display("FAIL single_valid: got %b expected %b", status(), exp_s); end
    n_checks++; if (frame_data !== exp_w) begin n_fail++; $display("FAIL single_data: got %h expected %h", frame_data, exp_w); end
    @(negedge clk);
    exp_s = 9'd0;
    n_checks++; if (status() !== exp_s) begin n_fail++; $display("FAIL single_pulse_end: got %b expected %b", status(), exp_s); end
    n_checks++; if (frame_data !== exp_w) begin n_fail++; $display("FAIL single_hold: got %h expected %h", frame_data, exp_w); end
    last_word = exp_w;
  endtask

  task automatic test_timeout();
    send_bytes(8'h50, 8'h01, 0, 4, 20);
    repeat (T - 1) @(negedge clk);
    exp_s = {1'b0, 1'b1, 1'b0, 1'b0, 5'd5};
    n_checks++; if (status() !== exp_s) begin n_fail++; $display("FAIL timeout_early: got %b expected %b", status(), exp_s); end
    @(negedge clk);
    exp_s = {1'b0, 1'b0, 1'b1, 1'b0, 5'd0};
    n_checks++; if (status() !== exp_s) begin n_fail++; $display("FAIL timeout_pulse: got %b expected %b", status(), exp_s); end
    n_checks++; if (frame_data !== last_word) begin n_fail++; $display("FAIL timeout_hold: got %h expected %h", frame_data, last_word); end
    @(negedge clk);
    exp_s = 9'd0;
    n_checks++; if (status() !== exp_s) begin n_fail++; $display("FAIL timeout_pulse_end: got %b expected %b", status(), exp_s); end
    send_bytes(8'h30, 8'h03, 0, FLEN - 1, 20);
    @(negedge clk);
    exp_s = {1'b1, 1'b0, 1'b0, 1'b0, 5'd0};
    exp_w = exp_word(8'h30, 8'h03);
    n_checks++; if (status() !== exp_s) begin n_fail++; $display("FAIL timeout_next_valid: got %b expected %b", status(), exp_s); end
    n_checks++; if (frame_data !== exp_w) begin n_fail++; $display("FAIL timeout_next_data: got %h expected %h", frame_data, exp_w); end
    last_word = exp_w;
  endtask

  task automatic test_rx_err();
    send_byte(8'hEE, 1'b1);
    exp_s = {1'b0, 1'b0, 1'b0, 1'b1, 5'd0};
    n_checks++; if (status() !== exp_s) begin n_fail++; $display("FAIL rxerr_idle: got %b expected %b", status(), exp_s); end
    send_bytes(8'h80, 8'h07, 0, 7, 20);
    exp_s = {1'b0, 1'b1, 1'b0, 1'b0, 5'd8};
    n_checks++; if (status() !== exp_s) begin n_fail++; $display("FAIL rxerr_mid: got %b expected %b", status(), exp_s); end
    repeat (19) @(negedge clk);
    send_byte(frame_byte(8'h80, 8'h07, 8), 1'b1);
    exp_s = {1'b0, 1'b0, 1'b0, 1'b1, 5'd0};
    n_checks++; if (status() !== exp_s) begin n_fail++; $display("FAIL rxerr_pulse: got %b expected %b", status(), exp_s); end
    @(negedge clk);
    exp_s = 9'd0;
    n_checks++; if (status() !== exp_s) begin n_fail++; $display("FAIL rxerr_pulse_end: got %b expected %b", status(), exp_s); end
    n_checks++; if (frame_data !== last_word) begin n_fail++; $display("FAIL rxerr_hold: got %h expected %h", frame_data, last_word); end
    send_bytes(8'hC0, 8'h05, 0, FLEN - 1, 20);
    @(negedge clk);
    exp_s = {1'b1, 1'b0, 1'b0, 1'b0, 5'd0};
    exp_w = exp_word(8'hC0, 8'h05);
    n_checks++; if (status() !== exp_s) begin n_fail++; $display("FAIL rxerr_next_valid: got %b expected %b", status(), exp_s); end
    n_checks++; if (frame_data !== exp_w) begin n_fail++; $display("FAIL rxerr_next_data: got %h expected %h", frame_data, exp_w); end
    last_word = exp_w;
  endtask

  task automatic test_reset_mid_frame();
    send_bytes(8'h11, 8'h02, 0, 9, 20);
    exp_s = {1'b0, 1'b1, 1'b0, 1'b0, 5'd10};
    n_checks++; if (status() !== exp_s) begin n_fail++; $display("FAIL midreset_before: got %b expected %b", status(), exp_s); end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    exp_s = 9'd0;
    n_checks++; if (status() !== exp_s) begin n_fail++; $display("FAIL midreset_status: got %b expected %b", status(), exp_s); end
    n_checks++; if (frame_data !== '0) begin n_fail++; $display("FAIL midreset_data: got %h expected 0", frame_data); end
    send_bytes(8'hAA, 8'h00, 0, FLEN - 1, 20);
    @(negedge clk);
    exp_s = {1'b1, 1'b0, 1'b0, 1'b0, 5'd0};
    exp_w = {FB{8'hAA}};
    n_checks++; if (status() !== exp_s) begin n_fail++; $display("FAIL midreset_next_valid: got %b expected %b", status(), exp_s); end
    n_checks++; if (frame_data !== exp_w) begin n_fail++; $display("FAIL midreset_next_data: got %h expected %h", frame_data, exp_w); end
    last_word = exp_w;
  endtask

  // Last byte lands on the timeout edge, then the next frame's first byte lands in the EMIT cycle.
  task automatic test_back_to_back();
    send_bytes(8'h10, 8'h01, 0, FLEN - 2, 20);
    repeat (T - 1) @(negedge clk);
    send_byte(frame_byte(8'h10, 8'h01, FLEN - 1), 1'b0);
    exp_s = {1'b0, 1'b1, 1'b0, 1'b0, 5'd0};
    n_checks++; if (status() !== exp_s) begin n_fail++; $display("FAIL b2b_byte_wins: got %b expected %b", status(), exp_s); end
    send_byte(frame_byte(8'h60, 8'h02, 0), 1'b0);
    exp_s = {1'b1, 1'b1, 1'b0, 1'b0, 5'd1};
    exp_w = exp_word(8'h10, 8'h01);
    n_checks++; if (status() !== exp_s) begin n_fail++; $display("FAIL b2b_emit_overlap: got %b expected %b", status(), exp_s); end
    n_checks++; if (frame_data !== exp_w) begin n_fail++; $display("FAIL b2b_first_data: got %h expected %h", frame_data, exp_w); end
    send_bytes(8'h60, 8'h02, 1, FLEN - 1, 20);
    @(negedge clk);
    exp_s = {1'b1, 1'b0, 1'b0, 1'b0, 5'd0};
    exp_w = exp_word(8'h60, 8'h02);
    n_checks++; if (status() !== exp_s) begin n_fail++; $display("FAIL b2b_second_valid: got %b expected %b", status(), exp_s); end
    n_checks++; if (frame_data !== exp_w) begin n_fail++; $display("FAIL b2b_second_data: got %h expected %h", frame_data, exp_w); end
    last_word = exp_w;
  endtask

`ifdef RX_FRAME_CHECKSUM_EN
  // XOR of 0x01..0x11 is 0x01.
  task automatic test_checksum();
    send_bytes(8'h01, 8'h01, 0, FB - 1, 20);
    exp_s = {1'b0, 1'b1, 1'b0, 1'b0, 5'd17};
    n_checks++; if (status() !== exp_s) begin n_fail++; $display("FAIL csum_count: got %b expected %b", status(), exp_s); end
    repeat (19) @(negedge clk);
    send_byte(8'h01, 1'b0);
    @(negedge clk);
    exp_w = 136'h0102030405060708090a0b0c0d0e0f1011;
    n_checks++; if ({frame_valid, csum_err} !== 2'b10) begin n_fail++; $display("FAIL csum_ok: got %b expected 10", {frame_valid, csum_err}); end
    n_checks++; if (frame_data !== exp_w) begin n_fail++; $display("FAIL csum_ok_data: got %h expected %h", frame_data, exp_w); end
    send_bytes(8'h02, 8'h01, 0, FB - 1, 20);
    repeat (19) @(negedge clk);
    send_byte(8'h00, 1'b0);
    @(negedge clk);
    n_checks++; if ({frame_valid, csum_err} !== 2'b01) begin n_fail++; $display("FAIL csum_bad: got %b expected 01", {frame_valid, csum_err}); end
    n_checks++; if (frame_data !== exp_w) begin n_fail++; $display("FAIL csum_bad_hold: got %h expected %h", frame_data, exp_w); end
    @(negedge clk);
    n_checks++; if (csum_err !== 1'b0) begin n_fail++; $display("FAIL csum_pulse_end: got %b expected 0", csum_err); end
  endtask
`endif

  initial begin
    test_reset();
    test_single_frame();
    test_timeout();
    test_rx_err();
    test_reset_mid_frame();
`ifdef RX_FRAME_CHECKSUM_EN
    test_checksum();
`endif
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached before the summary");
    $fatal(1, "watchdog expired");
  end

endmodule
